// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared types and constants for DVI receive timing recovery
package dvi_pkg;
    localparam int CORDW_DEF = 10;
    localparam int COLRW_DEF = 4;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} rx_state_t;
endpackage

// File: rtl/dvi_edge_detect.sv
// rtl/dvi_edge_detect.sv - two-flop input register with rise/fall/active-edge flags
module dvi_edge_detect #(
    parameter logic ACT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic act_edge
);
    logic q1, q2;

    // Reset to the idle level so a release never fabricates an active edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= ~ACT;
            q2 <= ~ACT;
        end else begin
            q1 <= d;
            q2 <= q1;
        end
    end

    assign q        = q1;
    assign rise     = q1 & ~q2;
    assign fall     = ~q1 & q2;
    assign act_edge = (q1 == ACT) && (q2 != ACT);
endmodule

// File: rtl/dvi_timing_rx.sv
// rtl/dvi_timing_rx.sv - DVI receive timing recovery: coordinates, size measurement, lock
module dvi_timing_rx #(
    parameter int   CORDW       = dvi_pkg::CORDW_DEF,
    parameter int   COLRW       = dvi_pkg::COLRW_DEF,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic             clk_pix,
    input  logic             reset_n_async_unsafe_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             de_i,
    input  logic [COLRW-1:0] r_i,
    input  logic [COLRW-1:0] g_i,
    input  logic [COLRW-1:0] b_i,
    output logic [CORDW-1:0] sx_o,
    output logic [CORDW-1:0] sy_o,
    output logic [COLRW-1:0] r_o,
    output logic [COLRW-1:0] g_o,
    output logic [COLRW-1:0] b_o,
    output logic             pix_valid_o,
    output logic             line_o,
    output logic             frame_o,
    output logic             locked_o,
    output logic [CORDW-1:0] width_o,
    output logic [CORDW-1:0] height_o,
    output logic             err_o
);
    import dvi_pkg::*;

    localparam logic [CORDW-1:0] CMAX   = '1;
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    logic rst_n;
    assign rst_n = reset_n_async_unsafe_i;

    logic de1, de_rise, de_fall, de_act;
    logic vs1, vs_rise, vs_fall, vs_edge;
    logic hs1;
    logic [COLRW-1:0] r1, g1, b1;
    logic unused_flags;

    dvi_edge_detect #(.ACT(1'b1)) u_de (
        .clk(clk_pix), .rst_n(rst_n), .d(de_i),
        .q(de1), .rise(de_rise), .fall(de_fall), .act_edge(de_act)
    );

    dvi_edge_detect #(.ACT(SYNC_POL)) u_vs (
        .clk(clk_pix), .rst_n(rst_n), .d(vsync_i),
        .q(vs1), .rise(vs_rise), .fall(vs_fall), .act_edge(vs_edge)
    );

    assign unused_flags = &{1'b0, de_act, vs_rise, vs_fall};

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            hs1 <= ~SYNC_POL;
            r1  <= '0;
            g1  <= '0;
            b1  <= '0;
        end else begin
            hs1 <= hsync_i;
            r1  <= r_i;
            g1  <= g_i;
            b1  <= b_i;
        end
    end

    logic [CORDW-1:0] x_cnt, y_cnt, x_next, y_next, y_inc, frame_h, line_w;
    logic             line_bad, viol_v, viol_h;

    // x_next/y_next are the coordinates of the pixel now in stage 1.
    always_comb begin
        x_next = x_cnt;
        if (de_rise)
            x_next = '0;
        else if (de1 && x_cnt != CMAX)
            x_next = x_cnt + CORDW'(1);
        y_inc   = (y_cnt == CMAX) ? y_cnt : y_cnt + CORDW'(1);
        frame_h = de_fall ? y_inc : y_cnt;
        y_next  = vs_edge ? '0 : frame_h;
    end

    assign line_w   = x_cnt + CORDW'(1);
    assign line_bad = (x_cnt == CMAX);
    assign viol_v   = de1 && (vs1 == SYNC_POL);
    assign viol_h   = de1 && (hs1 == SYNC_POL);

    logic             ev_line, ev_bad, ev_frame, ev_vde, ev_hde;
    logic [CORDW-1:0] ev_w, ev_h;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            ev_line  <= 1'b0;
            ev_bad   <= 1'b0;
            ev_w     <= '0;
            ev_frame <= 1'b0;
            ev_h     <= '0;
            ev_vde   <= 1'b0;
            ev_hde   <= 1'b0;
        end else begin
            x_cnt    <= x_next;
            y_cnt    <= y_next;
            ev_line  <= de_fall;
            ev_bad   <= de_fall && line_bad;
            ev_w     <= line_w;
            ev_frame <= vs_edge;
            ev_h     <= frame_h;
            ev_vde   <= viol_v;
            ev_hde   <= viol_h;
        end
    end

    rx_state_t        state;
    logic [CORDW-1:0] ref_w, ref_h;
    logic             have_w;
    logic [3:0]       match_cnt, match_inc;
    logic             w_mis, meas_mis;

    assign match_inc = match_cnt + 4'd1;
    assign w_mis     = ev_line && (ev_bad || ev_w != ref_w);
    assign meas_mis  = ev_line && (ev_bad || (have_w && ev_w != ref_w));

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            ref_w     <= '0;
            ref_h     <= '0;
            have_w    <= 1'b0;
            match_cnt <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            width_o   <= '0;
            height_o  <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                SEARCH: begin
                    if (ev_frame && !ev_vde && !ev_hde) begin
                        state  <= MEASURE;
                        have_w <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (ev_vde || ev_hde || meas_mis) begin
                        state <= SEARCH;
                    end else begin
                        if (ev_line && !have_w) begin
                            ref_w  <= ev_w;
                            have_w <= 1'b1;
                        end
                        if (ev_frame) begin
                            if (ev_h == '0) begin
                                state <= SEARCH;
                            end else begin
                                ref_h     <= ev_h;
                                match_cnt <= '0;
                                state     <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (ev_vde || ev_hde || w_mis) begin
                        state <= SEARCH;
                    end else if (ev_frame) begin
                        if (ev_h != ref_h) begin
                            state <= SEARCH;
                        end else if (match_inc == LOCK_N) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            width_o  <= ref_w;
                            height_o <= ref_h;
                        end else begin
                            match_cnt <= match_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (ev_vde || w_mis || (ev_frame && ev_h != ref_h)) begin
                        state    <= SEARCH;
                        locked_o <= 1'b0;
                        err_o    <= 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    logic pv;
    assign pv = de1 && (state == LOCKED);

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_o <= 1'b0;
            sx_o        <= '0;
            sy_o        <= '0;
            r_o         <= '0;
            g_o         <= '0;
            b_o         <= '0;
            line_o      <= 1'b0;
            frame_o     <= 1'b0;
        end else begin
            pix_valid_o <= pv;
            sx_o        <= x_next;
            sy_o        <= y_next;
            r_o         <= pv ? r1 : '0;
            g_o         <= pv ? g1 : '0;
            b_o         <= pv ? b1 : '0;
            line_o      <= pv && de_rise;
            frame_o     <= pv && de_rise && (y_next == '0);
        end
    end
endmodule

// File: tb/tb_dvi_timing_rx.sv
// tb/tb_dvi_timing_rx.sv - directed self-checking bench for dvi_timing_rx on a reduced raster
module tb_dvi_timing_rx;
    import dvi_pkg::*;

    localparam int W  = 6;
    localparam int H  = 4;
    localparam int HB = 4;
    localparam int LL = W + HB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hs = 1'b1, vs = 1'b1, de = 1'b0;
    logic [COLRW_DEF-1:0] r = '0, g = '0, b = '0;
    logic [CORDW_DEF-1:0] sx, sy, width, height;
    logic [COLRW_DEF-1:0] ro, go, bo;
    logic pix_valid, line_p, frame_p, locked, err;
    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int err_base;

    always #5 clk = ~clk;
    always @(negedge clk) if (err) err_cnt <= err_cnt + 1;

    dvi_timing_rx #(.CORDW(CORDW_DEF), .COLRW(COLRW_DEF), .SYNC_POL(1'b0), .LOCK_FRAMES(2)) dut (
        .clk_pix(clk), .reset_n_async_unsafe_i(rst_n),
        .hsync_i(hs), .vsync_i(vs), .de_i(de),
        .r_i(r), .g_i(g), .b_i(b),
        .sx_o(sx), .sy_o(sy), .r_o(ro), .g_o(go), .b_o(bo),
        .pix_valid_o(pix_valid), .line_o(line_p), .frame_o(frame_p),
        .locked_o(locked), .width_o(width), .height_o(height), .err_o(err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic d, input logic v, input int pos,
                       input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
        de = d;
        vs = v;
        hs = (pos == W + 1 || pos == W + 2) ? 1'b0 : 1'b1;
        r  = rr;
        g  = gg;
        b  = bb;
        tick();
    endtask

    task automatic rest(input int from, input int w);
        for (int i = from; i < LL; i++)
            if (i < w) cyc(1'b1, 1'b1, i, 4'(i), 4'hA, 4'h5);
            else       cyc(1'b0, 1'b1, i, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic line(input int w);
        rest(0, w);
    endtask

    task automatic vs_line();
        for (int i = 0; i < LL; i++) cyc(1'b0, 1'b0, i, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic vblank();
        line(0);
        vs_line();
        line(0);
    endtask

    task automatic frame(input int h);
        repeat (h) line(W);
        vblank();
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_width", width, 0);
        chk("rst_height", height, 0);
        chk("rst_line_frame", {line_p, frame_p}, 0);
        rst_n = 1'b1;

        // initial lock: edges 1..3, then exact rise on edge 4
        frame(H);
        frame(H);
        frame(H);
        chk("no_lock_3_edges", locked, 0);
        repeat (H) line(W);
        line(0);
        cyc(1'b0, 1'b0, 0, 4'h0, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 1, 4'h0, 4'h0, 4'h0);
        chk("lock_not_early", locked, 0);
        cyc(1'b0, 1'b0, 2, 4'h0, 4'h0, 4'h0);
        chk("lock_rise_3cyc", locked, 1);
        for (int i = 3; i < LL; i++) cyc(1'b0, 1'b0, i, 4'h0, 4'h0, 4'h0);
        line(0);
        chk("width_lock", width, W);
        chk("height_lock", height, H);

        // locked frame: latency, first pixel, line pulse, last pixel
        cyc(1'b1, 1'b1, 0, 4'hF, 4'h0, 4'hF);
        cyc(1'b1, 1'b1, 1, 4'h1, 4'h2, 4'h3);
        chk("p00_valid", pix_valid, 1);
        chk("p00_rgb", {ro, go, bo}, 12'hF0F);
        chk("p00_xy", {sx, sy}, 0);
        chk("p00_frame", frame_p, 1);
        chk("p00_line", line_p, 1);
        cyc(1'b1, 1'b1, 2, 4'h2, 4'hA, 4'h5);
        chk("p10_sx", sx, 1);
        chk("p10_rgb", {ro, go, bo}, 12'h123);
        chk("p10_pulses", {line_p, frame_p}, 0);
        rest(3, W);
        cyc(1'b1, 1'b1, 0, 4'h0, 4'hA, 4'h5);
        cyc(1'b1, 1'b1, 1, 4'h1, 4'hA, 4'h5);
        chk("line1_pulses", {line_p, frame_p}, 2'b10);
        chk("line1_xy", {sx, sy}, {10'd0, 10'd1});
        rest(2, W);
        line(W);
        for (int i = 0; i < W; i++) cyc(1'b1, 1'b1, i, 4'(i), 4'hA, 4'h5);
        cyc(1'b0, 1'b1, W, 4'h0, 4'h0, 4'h0);
        chk("last_valid", pix_valid, 1);
        chk("last_xy", {sx, sy}, {10'd5, 10'd3});
        chk("last_r", ro, 4'h5);
        cyc(1'b0, 1'b1, W + 1, 4'h0, 4'h0, 4'h0);
        chk("blank_valid", pix_valid, 0);
        chk("blank_rgb", {ro, go, bo}, 0);
        rest(W + 2, W);
        vblank();
        chk("still_locked", locked, 1);
        chk("no_err_clean", err_cnt, 0);

        // one short line while locked
        err_base = err_cnt;
        line(W);
        for (int i = 0; i < W - 1; i++) cyc(1'b1, 1'b1, i, 4'(i), 4'hA, 4'h5);
        cyc(1'b0, 1'b1, 5, 4'h0, 4'h0, 4'h0);
        cyc(1'b0, 1'b1, 6, 4'h0, 4'h0, 4'h0);
        chk("short_err_early", err, 0);
        chk("short_locked_early", locked, 1);
        cyc(1'b0, 1'b1, 7, 4'h0, 4'h0, 4'h0);
        chk("short_err_pulse", err, 1);
        chk("short_unlock", locked, 0);
        cyc(1'b0, 1'b1, 8, 4'h0, 4'h0, 4'h0);
        chk("short_err_single", err, 0);
        cyc(1'b0, 1'b1, 9, 4'h0, 4'h0, 4'h0);
        line(W);
        line(W);
        vblank();
        chk("short_err_count", err_cnt - err_base, 1);
        chk("short_width_hold", width, W);
        chk("short_unlocked", locked, 0);
        frame(H);
        chk("relock_e2", locked, 0);
        frame(H);
        chk("relock_e3", locked, 0);
        frame(H);
        chk("relock_e4", locked, 1);

        // reset mid-line while locked
        cyc(1'b1, 1'b1, 0, 4'h0, 4'hA, 4'h5);
        cyc(1'b1, 1'b1, 1, 4'h1, 4'hA, 4'h5);
        cyc(1'b1, 1'b1, 2, 4'h2, 4'hA, 4'h5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_valid", pix_valid, 0);
        chk("mid_rst_size", {width, height}, 0);
        chk("mid_rst_sx", sx, 0);
        chk("mid_rst_r", ro, 0);
        cyc(1'b1, 1'b1, 3, 4'h3, 4'hA, 4'h5);
        rst_n = 1'b1;
        rest(4, W);
        repeat (H - 1) line(W);
        vblank();

        // frames without de alternate SEARCH/MEASURE and never lock
        err_base = err_cnt;
        for (int k = 0; k < 5; k++) begin
            frame(0);
            chk("node_locked", locked, 0);
        end
        chk("node_no_err", err_cnt - err_base, 0);
        frame(H);
        chk("rst_relock_e1", locked, 0);
        frame(H);
        chk("rst_relock_e2", locked, 0);
        frame(H);
        chk("rst_relock_e3", locked, 0);
        frame(H);
        chk("rst_relock_e4", locked, 1);
        chk("rst_relock_size", {width, height}, {10'd6, 10'd4});

        // one extra line while in CHECK
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        frame(H);
        frame(H);
        err_base = err_cnt;
        frame(H + 1);
        chk("tall_no_lock", locked, 0);
        chk("tall_no_err", err_cnt - err_base, 0);
        frame(H);
        chk("tall_e1", locked, 0);
        frame(H);
        chk("tall_e2", locked, 0);
        frame(H);
        chk("tall_e3", locked, 0);
        frame(H);
        chk("tall_relock", locked, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dvi_timing_rx.md
# dvi_timing_rx

Receive-side timing recovery for the 12-bit parallel DVI Pmod bus (hsync, vsync, de, 4:4:4 RGB), the counterpart to the pixel-clock display controller. It registers the incoming bus, recovers per-pixel screen coordinates, measures active width and height, and declares lock once the timing is stable for a set number of frames. Downstream capture and compare logic uses only the coordinate-tagged pixel stream and `locked_o`.

## Interface
Parameters:
- CORDW, 10, coordinate and measurement width in bits
- COLRW, 4, bits per colour channel
- SYNC_POL, 1'b0, active level of hsync_i/vsync_i (0 = negative sync, 640x480)
- LOCK_FRAMES, 2, consecutive matching frames required for lock (1..15)

Ports:
- clk_pix  in  1  pixel clock; all logic on the rising edge
- reset_n_async_unsafe_i  in  1  asynchronous, active-low reset
- hsync_i, vsync_i, de_i  in  1 each  incoming sync and data enable
- r_i, g_i, b_i  in  COLRW each  incoming colour
- sx_o, sy_o  out  CORDW each  coordinate of the current output pixel
- r_o, g_o, b_o  out  COLRW each  colour of the current output pixel
- pix_valid_o  out  1  output pixel is valid (de high and locked)
- line_o  out  1  one-cycle pulse on the first pixel of each active line while locked
- frame_o  out  1  one-cycle pulse on pixel (0,0) while locked
- locked_o  out  1  timing stable
- width_o, height_o  out  CORDW each  locked active width and height in pixels
- err_o  out  1  one-cycle pulse when lock is lost

## Operation
- Stage 1 registers every input. Stage 2 keeps the previous stage-1 values for edge detection. A vsync edge means vsync goes to SYNC_POL. A de rise and de fall are the usual transitions.
- x_cnt clears on a de rise and then increments on each de-high cycle. At a de fall, line_w = x_cnt + 1. x_cnt saturates at all-ones, and a saturated line is a mismatch.
- y_cnt clears on a vsync edge and increments on each de fall. It stays at 0 on the first line.
- Frame end is the vsync edge. frame_h = the number of de falls since the previous vsync edge.
- FSM states are SEARCH, MEASURE, CHECK and LOCKED. The reset state is SEARCH.
  - SEARCH: waits for a vsync edge, then goes to MEASURE.
  - MEASURE:
    - The first line_w is latched into ref_w.
    - A later line_w that differs from ref_w sends the FSM to SEARCH.
    - At the next vsync edge, frame_h = 0 sends the FSM back to SEARCH.
    - Otherwise ref_h = frame_h, match_cnt = 0, and the FSM goes to CHECK.
  - CHECK:
    - Any line_w different from ref_w sends the FSM to SEARCH.
    - At a vsync edge, frame_h == ref_h increments match_cnt. On reaching LOCK_FRAMES the FSM goes to LOCKED. Otherwise it goes to SEARCH.
  - LOCKED:
    - A line_w mismatch, a frame_h mismatch, or de high while vsync is at its active level sends the FSM to SEARCH and pulses err_o.
- width_o and height_o load ref_w and ref_h on entry to LOCKED. They hold their value after lock is lost, until the next lock.
- Pixel output (registered stage 3):
  - pix_valid_o = stage-1 de AND (state == LOCKED).
  - sx_o/sy_o are x_cnt/y_cnt for that pixel. Colour passes through.
  - When pix_valid_o is low, colour outputs are 0.
- de high during vsync in SEARCH, MEASURE or CHECK restarts from SEARCH. It does not pulse err_o.
- hsync_i is only monitored for polarity sanity; it does not drive any counter. Line structure comes from de alone.

## Timing
- Reset: every output is 0 asynchronously, and the FSM is in SEARCH. Reset mid-frame discards all measurements. Relock needs the full SEARCH→LOCKED sequence again.
- Pixel latency: input at cycle n appears on the r/g/b/sx/sy/pix_valid outputs at cycle n+2.
- FSM decisions register in the cycle after the stage-2 edge detect.
  - locked_o rises 3 cycles after the vsync_i sample that completes the LOCK_FRAMES-th match.
  - err_o and the locked_o fall occur 3 cycles after the offending input sample.
- A vsync edge and a de fall in the same cycle: the de fall is counted in the ending frame first.
- line_o and frame_o coincide with pix_valid_o. frame_o implies line_o.

## Structure
- Shared package `dvi_pkg`:
  - `rx_state_t` enum (SEARCH, MEASURE, CHECK, LOCKED).
  - Default CORDW and COLRW.
  - 640x480 constants H_ACTIVE = 640 and V_ACTIVE = 480, for benches.
- One sub-module, `dvi_edge_detect`: a 2-flop input register plus rise/fall/active-edge outputs, instanced for de and vsync.

## Test plan
- Clean 640x480@60 stream from the existing controller, LOCK_FRAMES = 2:
  - locked_o goes high after the 4th vsync edge, with width_o = 640 and height_o = 480.
  - On the next frame, frame_o pulses with sx_o = 0, sy_o = 0, and the last valid pixel is (639,479).
- Latency check, locked: a de pulse with r_i = F, g_i = 0, b_i = F at cycle n gives pix_valid_o, r_o = F and b_o = F at cycle n+2.
- Locked, then one line shortened to 639 pixels: err_o pulses once, locked_o falls, width_o stays 640, and the FSM relocks after 3 further clean vsync edges.
- Frame with 481 lines during CHECK: the FSM returns to SEARCH, with no err_o and no lock.
- Reset asserted mid-line while locked: all outputs read 0 within the same cycle; after release, lock requires 4 vsync edges again.
- Frames with no de at all: the FSM cycles SEARCH→MEASURE→SEARCH and locked_o stays 0.
